// File: rtl/gold_nic.sv
// gold_nic: network interface between one processing element and its ring router.
// The PE-to-router path is a one-entry injection buffer, released only when the ring
// polarity matches the packet's vc bit. The router-to-PE path is a one-entry ejection
// buffer. Three saturating counters track forwarded, delivered and dropped packets.
module gold_nic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             polarity,
    input  logic             pesi,
    output logic             peri,
    input  logic [63:0]      pedi,
    output logic             peso,
    input  logic             pero,
    output logic [63:0]      pedo,
    output logic             net_so,
    input  logic             net_ro,
    output logic [63:0]      net_do,
    input  logic             net_si,
    output logic             net_ri,
    input  logic [63:0]      net_di,
    output logic [CNT_W-1:0] inj_cnt,
    output logic [CNT_W-1:0] ej_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             en);
        logic [CNT_W-1:0] res;
        if (en && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Buffer state
    logic [63:0]      r_inj_buf;
    logic             r_inj_full;
    logic [63:0]      r_ej_buf;
    logic             r_ej_full;
    logic [CNT_W-1:0] r_inj_cnt;
    logic [CNT_W-1:0] r_ej_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    // Handshake decodes
    logic w_pe_acc;
    logic w_hop_zero;
    logic w_inj_load;
    logic w_inj_drop;
    logic w_net_so;
    logic w_inj_fire;
    logic w_ej_load;
    logic w_ej_fire;

    // Decode the handshakes of both paths from the full flags and the valids.
    // Ready depends only on the full flag, so a draining buffer never refills
    // in the same cycle and the load/fire pairs are mutually exclusive.
    always_comb begin
        w_pe_acc   = 1'b0;
        w_hop_zero = 1'b0;
        w_inj_load = 1'b0;
        w_inj_drop = 1'b0;
        w_net_so   = 1'b0;
        w_inj_fire = 1'b0;
        w_ej_load  = 1'b0;
        w_ej_fire  = 1'b0;

        w_pe_acc   = pesi & ~r_inj_full;
        w_hop_zero = (pedi[55:48] == 8'h00);
        w_inj_load = w_pe_acc & ~w_hop_zero;
        w_inj_drop = w_pe_acc & w_hop_zero;
        w_net_so   = r_inj_full & (r_inj_buf[63] == polarity);
        w_inj_fire = w_net_so & net_ro;
        w_ej_load  = net_si & ~r_ej_full;
        w_ej_fire  = r_ej_full & pero;
    end

    // Injection buffer: latch a live PE packet, release it on a router handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inj_buf  <= 64'h0;
            r_inj_full <= 1'b0;
        end else if (w_inj_load) begin
            r_inj_buf  <= pedi;
            r_inj_full <= 1'b1;
        end else if (w_inj_fire) begin
            r_inj_full <= 1'b0;
        end else begin
            r_inj_full <= r_inj_full;
        end
    end

    // Ejection buffer: latch a router packet, release it on a PE handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ej_buf  <= 64'h0;
            r_ej_full <= 1'b0;
        end else if (w_ej_load) begin
            r_ej_buf  <= net_di;
            r_ej_full <= 1'b1;
        end else if (w_ej_fire) begin
            r_ej_full <= 1'b0;
        end else begin
            r_ej_full <= r_ej_full;
        end
    end

    // Statistics counters: each advances at most once per cycle and saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inj_cnt  <= CNT_ZERO;
            r_ej_cnt   <= CNT_ZERO;
            r_drop_cnt <= CNT_ZERO;
        end else begin
            r_inj_cnt  <= sat_inc(r_inj_cnt, w_inj_fire);
            r_ej_cnt   <= sat_inc(r_ej_cnt, w_ej_fire);
            r_drop_cnt <= sat_inc(r_drop_cnt, w_inj_drop);
        end
    end

    // Outputs come straight from state; only net_so also sees the live polarity.
    assign peri     = ~r_inj_full;
    assign net_so   = w_net_so;
    assign net_do   = r_inj_buf;
    assign net_ri   = ~r_ej_full;
    assign peso     = r_ej_full;
    assign pedo     = r_ej_buf;
    assign inj_cnt  = r_inj_cnt;
    assign ej_cnt   = r_ej_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_gold_nic.sv
// Self-checking bench for gold_nic: a table of injection vectors, hand-written
// back-pressure / stall / reset sequences, a random concurrent-traffic phase, and
// a negedge scoreboard that predicts every output from queues of expected packets.
// A second instance with 4-bit counters shares all inputs to exercise saturation.
module tb_gold_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity = 1'b0;
    logic        pesi, pero, net_ro, net_si;
    logic [63:0] pedi, net_di;
    logic        peri, peso, net_so, net_ri;
    logic [63:0] pedo, net_do;
    logic [15:0] inj_cnt, ej_cnt, drop_cnt;

    logic        s_peri, s_peso, s_net_so, s_net_ri;
    logic [63:0] s_pedo, s_net_do;
    logic [3:0]  s_inj_cnt, s_ej_cnt, s_drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [63:0] inj_q[$];
    logic [63:0] ej_q[$];
    int exp_inj  = 0;
    int exp_ej   = 0;
    int exp_drop = 0;

    gold_nic #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .pesi(pesi), .peri(peri), .pedi(pedi),
        .peso(peso), .pero(pero), .pedo(pedo),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
        .inj_cnt(inj_cnt), .ej_cnt(ej_cnt), .drop_cnt(drop_cnt)
    );

    gold_nic #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .polarity(polarity),
        .pesi(pesi), .peri(s_peri), .pedi(pedi),
        .peso(s_peso), .pero(pero), .pedo(s_pedo),
        .net_so(s_net_so), .net_ro(net_ro), .net_do(s_net_do),
        .net_si(net_si), .net_ri(s_net_ri), .net_di(net_di),
        .inj_cnt(s_inj_cnt), .ej_cnt(s_ej_cnt), .drop_cnt(s_drop_cnt)
    );

    always #5 clk = ~clk;

    // The router's polarity flips every cycle.
    always @(posedge clk) polarity <= ~polarity;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare outputs against the model, then apply the handshakes
    // that will take effect at the coming rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            logic m_inj_full, m_ej_full, m_so;
            logic [63:0] m_inj_pkt, m_ej_pkt;
            m_inj_full = (inj_q.size() != 0);
            m_ej_full  = (ej_q.size() != 0);
            m_inj_pkt  = m_inj_full ? inj_q[0] : 64'h0;
            m_ej_pkt   = m_ej_full ? ej_q[0] : 64'h0;
            m_so       = m_inj_full && (m_inj_pkt[63] == polarity);

            chk("peri", 64'(peri), 64'(!m_inj_full));
            chk("net_so", 64'(net_so), 64'(m_so));
            chk("net_ri", 64'(net_ri), 64'(!m_ej_full));
            chk("peso", 64'(peso), 64'(m_ej_full));
            if (m_inj_full) chk("net_do", net_do, m_inj_pkt);
            if (m_ej_full)  chk("pedo", pedo, m_ej_pkt);
            chk("inj_cnt", 64'(inj_cnt), 64'(sat(exp_inj, 65535)));
            chk("ej_cnt", 64'(ej_cnt), 64'(sat(exp_ej, 65535)));
            chk("drop_cnt", 64'(drop_cnt), 64'(sat(exp_drop, 65535)));
            chk("small_ctl", 64'({s_peri, s_net_so, s_net_ri, s_peso}),
                64'({!m_inj_full, m_so, !m_ej_full, m_ej_full}));
            if (m_inj_full) chk("small_net_do", s_net_do, m_inj_pkt);
            if (m_ej_full)  chk("small_pedo", s_pedo, m_ej_pkt);
            chk("small_inj_cnt", 64'(s_inj_cnt), 64'(sat(exp_inj, 15)));
            chk("small_ej_cnt", 64'(s_ej_cnt), 64'(sat(exp_ej, 15)));
            chk("small_drop_cnt", 64'(s_drop_cnt), 64'(sat(exp_drop, 15)));

            if (m_so && net_ro) begin
                void'(inj_q.pop_front());
                exp_inj++;
            end
            if (m_ej_full && pero) begin
                void'(ej_q.pop_front());
                exp_ej++;
            end
            if (pesi && !m_inj_full) begin
                if (pedi[55:48] != 8'h00) inj_q.push_back(pedi);
                else exp_drop++;
            end
            if (net_si && !m_ej_full) ej_q.push_back(net_di);
        end
    end

    typedef struct {
        logic        vc;
        logic        dir;
        logic [5:0]  rsv;
        logic [7:0]  hop;
        logic [15:0] src;
        logic [31:0] pay;
        logic        fwd;
        int          exp_inj;
        int          exp_drop;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [63:0] pk, pa, pb, tmp;

        vt[0] = '{1'b0, 1'b1, 6'h00, 8'h01, 16'h0001, 32'h0000_0001, 1'b1, 1, 0};
        vt[1] = '{1'b1, 1'b0, 6'h00, 8'h03, 16'h0005, 32'h0000_0002, 1'b1, 2, 0};
        vt[2] = '{1'b0, 1'b0, 6'h00, 8'h00, 16'h0007, 32'hDEAD_BEEF, 1'b0, 2, 1};
        vt[3] = '{1'b1, 1'b1, 6'h3F, 8'hFF, 16'hFFFF, 32'hFFFF_FFFF, 1'b1, 3, 1};
        vt[4] = '{1'b1, 1'b0, 6'h15, 8'h00, 16'h0042, 32'h1234_5678, 1'b0, 3, 2};
        vt[5] = '{1'b0, 1'b1, 6'h2A, 8'h80, 16'h1234, 32'hA5A5_A5A5, 1'b1, 4, 2};

        reset  = 1'b1;
        pesi   = 1'b0;
        pedi   = 64'h0;
        pero   = 1'b0;
        net_ro = 1'b1;
        net_si = 1'b0;
        net_di = 64'h0;

        // Reset values, before any clock edge.
        #1;
        chk("rst_peri", 64'(peri), 64'h1);
        chk("rst_net_ri", 64'(net_ri), 64'h1);
        chk("rst_peso", 64'(peso), 64'h0);
        chk("rst_net_so", 64'(net_so), 64'h0);
        chk("rst_pedo", pedo, 64'h0);
        chk("rst_net_do", net_do, 64'h0);
        chk("rst_cnts", 64'({inj_cnt, ej_cnt, drop_cnt}), 64'h0);
        step();
        step();
        reset = 1'b0;
        step();

        // Table-driven injections with the router always ready.
        for (int i = 0; i < 6; i++) begin
            pk   = {vt[i].vc, vt[i].dir, vt[i].rsv, vt[i].hop, vt[i].src, vt[i].pay};
            pesi = 1'b1;
            pedi = pk;
            step();
            pesi = 1'b0;
            pedi = {$urandom(), $urandom()};
            chk("vec_peri_after", 64'(peri), 64'(!vt[i].fwd));
            chk("vec_so_first", 64'(net_so), 64'(vt[i].fwd && (vt[i].vc == polarity)));
            if (vt[i].fwd) chk("vec_net_do", net_do, pk);
            for (int k = 0; k < 4 && inj_q.size() != 0; k++) step();
            step();
            chk("vec_peri_ret", 64'(peri), 64'h1);
            chk("vec_inj_cnt", 64'(inj_cnt), 64'(vt[i].exp_inj));
            chk("vec_drop_cnt", 64'(drop_cnt), 64'(vt[i].exp_drop));
        end

        // Injection back-pressure: router stalled for six cycles.
        net_ro = 1'b0;
        pk     = {1'b1, 1'b0, 6'h00, 8'h03, 16'h0009, 32'h0000_0002};
        pesi   = 1'b1;
        pedi   = pk;
        step();
        pesi = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("bp_peri", 64'(peri), 64'h0);
            chk("bp_so", 64'(net_so), 64'(polarity == 1'b1));
            chk("bp_do", net_do, pk);
            step();
        end
        net_ro = 1'b1;
        for (int k = 0; k < 4 && inj_q.size() != 0; k++) step();
        step();
        chk("bp_peri_ret", 64'(peri), 64'h1);
        chk("bp_inj_cnt", 64'(inj_cnt), 64'd5);

        // Ejection with a stalled PE; a second router packet must wait.
        pa     = {1'b0, 1'b1, 6'h00, 8'h02, 16'h0002, 32'h0000_0003};
        pb     = {1'b1, 1'b0, 6'h00, 8'h04, 16'h0003, 32'h0000_0004};
        pero   = 1'b0;
        net_si = 1'b1;
        net_di = pa;
        step();
        net_di = pb;
        for (int k = 0; k < 4; k++) begin
            chk("ej_stall_net_ri", 64'(net_ri), 64'h0);
            chk("ej_stall_peso", 64'(peso), 64'h1);
            chk("ej_stall_pedo", pedo, pa);
            step();
        end
        pero = 1'b1;
        step();
        chk("ej_cnt_first", 64'(ej_cnt), 64'd1);
        chk("ej_no_refill", 64'(peso), 64'h0);
        chk("ej_net_ri_ret", 64'(net_ri), 64'h1);
        step();
        net_si = 1'b0;
        chk("ej_second_peso", 64'(peso), 64'h1);
        chk("ej_second_pedo", pedo, pb);
        step();
        chk("ej_second_done", 64'(peso), 64'h0);
        chk("ej_cnt_second", 64'(ej_cnt), 64'd2);

        // Concurrent traffic: handshakes offered on both paths every other cycle.
        for (int i = 0; i < 240; i++) begin
            tmp = {$urandom(), $urandom()};
            tmp[55:48] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            pesi   = (i % 2 == 0);
            pedi   = tmp;
            net_si = (i % 2 == 0);
            net_di = {$urandom(), $urandom()};
            net_ro = ($urandom_range(0, 3) != 0);
            pero   = ($urandom_range(0, 3) != 0);
            step();
        end
        pesi   = 1'b0;
        net_si = 1'b0;
        net_ro = 1'b1;
        pero   = 1'b1;
        for (int k = 0; k < 8 && (inj_q.size() != 0 || ej_q.size() != 0); k++) step();
        step();
        chk("conc_peri", 64'(peri), 64'h1);
        chk("conc_net_ri", 64'(net_ri), 64'h1);
        chk("conc_ej_cnt", 64'(ej_cnt), 64'(exp_ej));
        chk("conc_inj_cnt", 64'(inj_cnt), 64'(exp_inj));
        chk("sat_small_inj", 64'(s_inj_cnt), 64'hF);
        chk("sat_small_ej", 64'(s_ej_cnt), 64'hF);

        // Mid-cycle reset with both buffers full.
        net_ro = 1'b0;
        pero   = 1'b0;
        pesi   = 1'b1;
        pedi   = {1'b0, 1'b0, 6'h00, 8'h02, 16'h00AA, 32'h0000_00BB};
        net_si = 1'b1;
        net_di = {1'b1, 1'b1, 6'h00, 8'h05, 16'h00CC, 32'h0000_00DD};
        step();
        pesi   = 1'b0;
        net_si = 1'b0;
        step();
        chk("pre_rst_peri", 64'(peri), 64'h0);
        chk("pre_rst_peso", 64'(peso), 64'h1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_peri", 64'(peri), 64'h1);
        chk("mid_rst_net_ri", 64'(net_ri), 64'h1);
        chk("mid_rst_peso", 64'(peso), 64'h0);
        chk("mid_rst_net_so", 64'(net_so), 64'h0);
        chk("mid_rst_pedo", pedo, 64'h0);
        chk("mid_rst_net_do", net_do, 64'h0);
        chk("mid_rst_cnts", 64'({inj_cnt, ej_cnt, drop_cnt}), 64'h0);
        inj_q.delete();
        ej_q.delete();
        exp_inj  = 0;
        exp_ej   = 0;
        exp_drop = 0;
        step();
        reset  = 1'b0;
        net_ro = 1'b1;
        pero   = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gold_nic.md
# gold_nic

Network interface sitting between one processing element (PE) and its gold_ring router node. It accepts PE packets over the pesi/peri/pedi handshake and forwards them to the router, gated by the ring's polarity. It also buffers packets ejected by the router and presents them to the PE over peso/pero/pedo. Saturating injection, ejection and drop counters are provided for gather-test accounting.

## Interface
- CNT_W, 16, width of the statistics counters
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears all state
- polarity  input  1  ring polarity from the router; toggles every cycle
- pesi  input  1  PE send valid
- peri  output  1  NIC ready to accept from the PE
- pedi  input  64  PE packet in: [63] vc, [62] dir, [61:56] reserved, [55:48] hop, [47:32] source, [31:0] payload
- peso  output  1  NIC has an ejected packet for the PE
- pero  input  1  PE ready to take the ejected packet
- pedo  output  64  ejected packet to the PE, same field layout as pedi
- net_so  output  1  injection valid toward the router
- net_ro  input  1  router injection ready
- net_do  output  64  injection packet toward the router
- net_si  input  1  router ejection valid
- net_ri  output  1  NIC ready to accept an ejection
- net_di  input  64  ejected packet from the router
- inj_cnt  output  CNT_W  packets forwarded to the router
- ej_cnt  output  CNT_W  packets delivered to the PE
- drop_cnt  output  CNT_W  PE packets discarded for hop == 0

## Operation
- **Injection buffer:** one 64-bit entry plus an inj_full flag.
  - peri = ~inj_full.
  - On pesi & peri at a clock edge:
    - if pedi[55:48] != 0: latch pedi and set inj_full.
    - if pedi[55:48] == 0: discard the packet, increment drop_cnt, and leave inj_full at 0.
- **Forwarding:** net_so = inj_full & (inj_buf[63] == polarity). net_do = inj_buf at all times.
  - On net_so & net_ro: clear inj_full and increment inj_cnt.
  - The packet is forwarded unmodified; hop decrement is the router's job.
- **Ejection buffer:** one 64-bit entry plus an ej_full flag.
  - net_ri = ~ej_full.
  - On net_si & net_ri: latch net_di and set ej_full.
  - peso = ej_full. pedo = ej_buf.
  - On peso & pero: clear ej_full and increment ej_cnt.
- **No same-cycle refill:** the ready signals depend only on the full flags. A buffer that drains in a cycle cannot accept a new packet in that same cycle.
- **Independence:** the injection and ejection paths are fully independent. Concurrent events on both paths in one cycle are all honoured.
- **Counters:** all three saturate at all-ones and never wrap. Each increments at most once per cycle.
- **Input qualification:** pedi and net_di are don't-care while their valid signal is low.

## Timing
- **Reset values:** peri=1, net_ri=1, peso=0, net_so=0, pedo=0, net_do=0, all counters=0, both full flags=0.
- **Reset mid-operation:** buffered packets are lost. Outputs take their reset values immediately, without waiting for a clock.
- **Minimum injection latency:** PE handshake at edge N gives inj_full=1 after N. net_so is high in cycle N+1 if polarity matches the vc bit; otherwise in cycle N+2.
- **Ejection latency:** router handshake at edge N gives peso=1 in cycle N+1.
- **Throughput:** one packet per 2 cycles per path at best. With polarity gating, a stalled vc can wait up to one extra cycle per attempt.
- **Back-pressure:**
  - net_ro low holds net_so and net_do stable while the polarity matches.
  - net_so deasserts on a non-matching polarity and reasserts on the next matching one. Data is unchanged throughout.
- **Hold while unaccepted:** pero low holds peso and pedo stable indefinitely.

## Test plan
- **Reset check:** assert reset mid-cycle with both buffers full. peso, net_so and the counters go to 0 asynchronously; peri and net_ri go to 1.
- **Polarity gating:** inject pedi={vc=0, dir=1, hop=8'h01, source=1, payload=1} with net_ro=1.
  - net_so rises only in a cycle with polarity=0.
  - net_do equals pedi bit-exact.
  - inj_cnt=1; peri returns high the cycle after acceptance.
- **Injection back-pressure:** inject vc=1, hop=8'h03, payload=2 with net_ro=0 for 6 cycles.
  - net_so toggles with polarity; net_do holds; peri stays 0.
  - Raise net_ro: the packet leaves on the first polarity=1 cycle.
- **Hop-zero drop:** inject with hop=8'h00. drop_cnt=1, inj_cnt=0, net_so never asserts, peri stays 1.
- **Ejection with stalled PE:** drive net_si with payload=3, source=2, and pero=0 for 4 cycles.
  - net_ri=0 and peso=1 hold, with pedo equal to net_di.
  - A second net_si is not accepted.
  - Set pero=1: ej_cnt=1, then the second packet is accepted the next cycle.
- **Counter saturation and concurrency:** preload by running traffic for 65,540 injections.
  - inj_cnt saturates at 16'hFFFF.
  - With simultaneous injection and ejection handshakes every other cycle, no packet is lost and ej_cnt matches the number of PE pero handshakes.
